// File: rtl/static_port_lookup_pkg.sv
// Shared definitions for the static port lookup stage.
//   - default IOQ module-header ctrl marker
//   - IOQ header field offsets (destination-port one-hot, source port)
//   - FSM state encoding
//   - helper mapping a source port to its paired destination (MAC<->CPU)
package static_port_lookup_pkg;

   localparam logic [7:0] IOQ_STAGE_DEFAULT = 8'hFF;

   // IOQ module header layout
   localparam int DST_HI = 63;
   localparam int DST_LO = 48;
   localparam int SRC_HI = 31;
   localparam int SRC_LO = 16;

   typedef enum logic [1:0] {
      S_HDR  = 2'd0,
      S_PASS = 2'd1,
      S_DROP = 2'd2
   } state_t;

   // Ports are paired: even MAC port n <-> odd CPU port n^1.
   // The result is the one-hot destination-port mask.
   function automatic logic [15:0] dst_for_src(input logic [15:0] src);
      return 16'h1 << (src ^ 16'h1);
   endfunction

endpackage

// File: rtl/static_port_lookup_small_fifo.sv
// Small first-word-fall-through FIFO feeding the lookup stage.
// Ports:
//   clk, reset     clock, asynchronous active-high reset (flushes the FIFO)
//   din, wr_en     write side; writes while full are ignored
//   rd_en          pop the head word; ignored while empty
//   dout           current head word (valid while !empty)
//   nearly_full    at most one free slot left
//   empty          no words stored
module static_port_lookup_small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             nearly_full,
   output logic             empty
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;
   localparam logic [MAX_DEPTH_BITS:0] DEPTH_FULL   = (MAX_DEPTH_BITS+1)'(DEPTH);
   localparam logic [MAX_DEPTH_BITS:0] DEPTH_NEARLY = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

   logic [WIDTH-1:0]          mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_reg;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr_reg;
   logic [MAX_DEPTH_BITS:0]   count_reg;
   logic                      do_wr;
   logic                      do_rd;

   assign do_wr = wr_en && (count_reg != DEPTH_FULL);
   assign do_rd = rd_en && (count_reg != '0);

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_wr)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_rd)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign dout        = mem[rd_ptr_reg];
   assign empty       = (count_reg == '0);
   assign nearly_full = (count_reg >= DEPTH_NEARLY);

endmodule

// File: rtl/static_port_lookup.sv
// Static port lookup stage: rewrites the destination-port field of each
// packet's IOQ module header from a fixed source->destination pairing,
// drops malformed packets or packets with an out-of-range source port,
// and counts forwarded / dropped packets.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_data/in_ctrl/in_wr      word stream from the input arbiter
//   in_rdy                     room in the input FIFO (one slot margin)
//   out_data/out_ctrl/out_wr   word stream to the output queues (registered)
//   out_rdy                    downstream can accept a word
//   pkt_fwd_cnt/pkt_drop_cnt   wrapping packet counters
module static_port_lookup
   import static_port_lookup_pkg::*;
#(
   parameter int                    DATA_WIDTH        = 64,
   parameter int                    CTRL_WIDTH        = DATA_WIDTH / 8,
   parameter int                    NUM_OUTPUT_QUEUES = 8,
   parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM     = IOQ_STAGE_DEFAULT,
   parameter int                    FIFO_DEPTH_BITS   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   output logic [31:0]           pkt_fwd_cnt,
   output logic [31:0]           pkt_drop_cnt
);

   localparam int FW = DATA_WIDTH + CTRL_WIDTH;

   logic [FW-1:0]         fifo_dout;
   logic                  fifo_empty;
   logic                  fifo_nearly_full;
   logic                  fifo_rd;
   logic [DATA_WIDTH-1:0] head_data;
   logic [CTRL_WIDTH-1:0] head_ctrl;
   logic [15:0]           head_src;
   logic                  hdr_ok;
   logic                  is_eop;
   logic [DATA_WIDTH-1:0] hdr_rewritten;
   state_t                state_reg;
   logic                  seen_data_reg;

   static_port_lookup_small_fifo #(
      .WIDTH          (FW),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .din         ({in_ctrl, in_data}),
      .wr_en       (in_wr),
      .rd_en       (fifo_rd),
      .dout        (fifo_dout),
      .nearly_full (fifo_nearly_full),
      .empty       (fifo_empty)
   );

   assign in_rdy    = !fifo_nearly_full;
   assign head_data = fifo_dout[DATA_WIDTH-1:0];
   assign head_ctrl = fifo_dout[FW-1 -: CTRL_WIDTH];
   assign head_src  = head_data[SRC_HI:SRC_LO];
   assign hdr_ok    = (head_ctrl == IOQ_STAGE_NUM) && (head_src < 16'(NUM_OUTPUT_QUEUES));
   // EOP is the first non-zero ctrl word after at least one data word.
   assign is_eop    = (head_ctrl != '0) && seen_data_reg;

   always_comb begin
      hdr_rewritten                = head_data;
      hdr_rewritten[DST_HI:DST_LO] = dst_for_src(head_src);
   end

   // Words that will be forwarded need out_rdy; discarded words never wait.
   always_comb begin
      fifo_rd = 1'b0;
      if (!fifo_empty) begin
         case (state_reg)
            S_HDR:   fifo_rd = hdr_ok ? out_rdy : 1'b1;
            S_PASS:  fifo_rd = out_rdy;
            S_DROP:  fifo_rd = 1'b1;
            default: fifo_rd = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= S_HDR;
         seen_data_reg <= 1'b0;
         out_wr        <= 1'b0;
         out_data      <= '0;
         out_ctrl      <= '0;
         pkt_fwd_cnt   <= '0;
         pkt_drop_cnt  <= '0;
      end else begin
         out_wr <= 1'b0;
         if (fifo_rd) begin
            case (state_reg)
               S_HDR: begin
                  seen_data_reg <= 1'b0;
                  if (hdr_ok) begin
                     out_wr    <= 1'b1;
                     out_data  <= hdr_rewritten;
                     out_ctrl  <= head_ctrl;
                     state_reg <= S_PASS;
                  end else begin
                     state_reg <= S_DROP;
                  end
               end
               S_PASS: begin
                  out_wr   <= 1'b1;
                  out_data <= head_data;
                  out_ctrl <= head_ctrl;
                  if (head_ctrl == '0) begin
                     seen_data_reg <= 1'b1;
                  end else if (is_eop) begin
                     seen_data_reg <= 1'b0;
                     pkt_fwd_cnt   <= pkt_fwd_cnt + 32'd1;
                     state_reg     <= S_HDR;
                  end
               end
               S_DROP: begin
                  if (head_ctrl == '0) begin
                     seen_data_reg <= 1'b1;
                  end else if (is_eop) begin
                     seen_data_reg <= 1'b0;
                     pkt_drop_cnt  <= pkt_drop_cnt + 32'd1;
                     state_reg     <= S_HDR;
                  end
               end
               default: state_reg <= S_HDR;
            endcase
         end
      end
   end

endmodule
